// File: rtl/read_txn_tracker_pkg.sv
// Shared types for the AXI read transaction tracker and its budget comparator.
package read_monitor_pkg;

    localparam int LatencyWidthDefault = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_AR_WAIT = 3'd1;
    localparam state_t ST_R_WAIT  = 3'd2;
    localparam state_t ST_R_BURST = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        PH_AR_READY = 2'd0,
        PH_AR_TO_R  = 2'd1,
        PH_R_READY  = 2'd2,
        PH_R_LAST   = 2'd3
    } phase_t;

endpackage

// File: rtl/read_txn_tracker_if.sv
// AXI read handshake plus counter-unit link seen by one tracker slot.
interface read_txn_tracker_if #(
    parameter int LatencyWidth = read_monitor_pkg::LatencyWidthDefault
);

    logic ar_valid;
    logic ar_ready;
    logic r_valid;
    logic r_ready;
    logic r_last;

    logic [LatencyWidth-1:0] latency_arvld_arrdy;
    logic [LatencyWidth-1:0] latency_arvld_rvld;
    logic [LatencyWidth-1:0] latency_rvld_rrdy;
    logic [LatencyWidth-1:0] latency_rvld_rlast;

    logic ena_ar;
    logic ena_r;
    logic clear_arvld_arrdy;
    logic clear_arvld_rvld;
    logic clear_rvld_rrdy;
    logic clear_rvld_rlast;

    modport master (
        output ar_valid, ar_ready, r_valid, r_ready, r_last,
        output latency_arvld_arrdy, latency_arvld_rvld,
        output latency_rvld_rrdy, latency_rvld_rlast,
        input  ena_ar, ena_r,
        input  clear_arvld_arrdy, clear_arvld_rvld,
        input  clear_rvld_rrdy, clear_rvld_rlast
    );

    modport slave (
        input  ar_valid, ar_ready, r_valid, r_ready, r_last,
        input  latency_arvld_arrdy, latency_arvld_rvld,
        input  latency_rvld_rrdy, latency_rvld_rlast,
        output ena_ar, ena_r,
        output clear_arvld_arrdy, clear_arvld_rvld,
        output clear_rvld_rrdy, clear_rvld_rlast
    );

endinterface

// File: rtl/read_txn_tracker_budget_cmp.sv
// Combinational latency-vs-budget check for the phase(s) live in a tracker state.
module read_budget_cmp
    import read_monitor_pkg::*;
#(
    parameter int LatencyWidth = LatencyWidthDefault
) (
    input  state_t                  state,
    input  logic [LatencyWidth-1:0] latency_arvld_arrdy,
    input  logic [LatencyWidth-1:0] latency_arvld_rvld,
    input  logic [LatencyWidth-1:0] latency_rvld_rrdy,
    input  logic [LatencyWidth-1:0] latency_rvld_rlast,
    input  logic [LatencyWidth-1:0] budget_arvld_arrdy,
    input  logic [LatencyWidth-1:0] budget_arvld_rvld,
    input  logic [LatencyWidth-1:0] budget_rvld_rrdy,
    input  logic [LatencyWidth-1:0] budget_rvld_rlast,
    output logic                    hit,
    output phase_t                  phase
);

    typedef logic [LatencyWidth-1:0] latency_t;

    // A zero budget disables that phase's check.
    function automatic logic over(latency_t lat, latency_t bud);
        return (bud != '0) && (lat >= bud);
    endfunction

    logic hit_aa;
    logic hit_ar;
    logic hit_rr;
    logic hit_rl;

    assign hit_aa = over(latency_arvld_arrdy, budget_arvld_arrdy);
    assign hit_ar = over(latency_arvld_rvld, budget_arvld_rvld);
    assign hit_rr = over(latency_rvld_rrdy, budget_rvld_rrdy);
    assign hit_rl = over(latency_rvld_rlast, budget_rvld_rlast);

    always_comb begin
        hit   = 1'b0;
        phase = PH_AR_READY;
        unique case (1'b1)
            (state == ST_AR_WAIT): begin
                hit   = hit_aa;
                phase = PH_AR_READY;
            end
            (state == ST_R_WAIT): begin
                hit   = hit_ar;
                phase = PH_AR_TO_R;
            end
            (state == ST_R_BURST): begin
                hit   = hit_rr | hit_rl;
                phase = hit_rr ? PH_R_READY : PH_R_LAST;
            end
            default: begin
                hit   = 1'b0;
                phase = PH_AR_READY;
            end
        endcase
    end

endmodule

// File: rtl/read_txn_tracker.sv
// Per-slot AXI read tracker: drives counter enables/clears, flags budget timeouts.
// Optional statistics outputs are built when READ_TRACKER_STATS_EN is defined.
module read_txn_tracker
    import read_monitor_pkg::*;
#(
    parameter int LatencyWidth = LatencyWidthDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    read_txn_tracker_if.slave       axi,
    input  logic [LatencyWidth-1:0] budget_arvld_arrdy_i,
    input  logic [LatencyWidth-1:0] budget_arvld_rvld_i,
    input  logic [LatencyWidth-1:0] budget_rvld_rrdy_i,
    input  logic [LatencyWidth-1:0] budget_rvld_rlast_i,
    input  logic                    timeout_ack_i,
    output logic                    busy_o,
    output logic                    timeout_o,
`ifdef READ_TRACKER_STATS_EN
    output logic [31:0]             txn_count_o,
    output logic [LatencyWidth-1:0] max_arvld_rvld_o,
`endif
    output logic [1:0]              timeout_phase_o
);

    state_t state_q;
    state_t state_d;
    logic   busy_q;
    logic   to_q;
    phase_t ph_q;

    logic   st_idle;
    logic   st_ar_wait;
    logic   st_r_wait;
    logic   st_r_burst;
    logic   st_timeout;

    logic   r_hs;
    logic   r_done;
    logic   complete;
    logic   ack;
    logic   beat;
    logic   clr_all;
    logic   to_set;
    logic   cmp_hit;
    phase_t cmp_phase;

    assign st_idle    = (state_q == ST_IDLE);
    assign st_ar_wait = (state_q == ST_AR_WAIT);
    assign st_r_wait  = (state_q == ST_R_WAIT);
    assign st_r_burst = (state_q == ST_R_BURST);
    assign st_timeout = (state_q == ST_TIMEOUT);

    assign r_hs     = axi.r_valid & axi.r_ready;
    assign r_done   = r_hs & axi.r_last;
    assign complete = (st_r_wait | st_r_burst) & r_done;
    assign ack      = st_timeout & timeout_ack_i;
    assign beat     = st_r_burst & r_hs & ~axi.r_last;

    read_budget_cmp #(
        .LatencyWidth(LatencyWidth)
    ) u_cmp (
        .state               (state_q),
        .latency_arvld_arrdy (axi.latency_arvld_arrdy),
        .latency_arvld_rvld  (axi.latency_arvld_rvld),
        .latency_rvld_rrdy   (axi.latency_rvld_rrdy),
        .latency_rvld_rlast  (axi.latency_rvld_rlast),
        .budget_arvld_arrdy  (budget_arvld_arrdy_i),
        .budget_arvld_rvld   (budget_arvld_rvld_i),
        .budget_rvld_rrdy    (budget_rvld_rrdy_i),
        .budget_rvld_rlast   (budget_rvld_rlast_i),
        .hit                 (cmp_hit),
        .phase               (cmp_phase)
    );

    // Any handshake that ends the live phase takes priority over a budget hit.
    always_comb begin
        state_d = state_q;
        to_set  = 1'b0;
        unique case (1'b1)
            st_idle: begin
                if (axi.ar_valid)
                    state_d = axi.ar_ready ? ST_R_WAIT : ST_AR_WAIT;
            end
            st_ar_wait: begin
                if (axi.ar_ready) state_d = ST_R_WAIT;
                else              to_set  = cmp_hit;
            end
            st_r_wait: begin
                if (r_done)           state_d = ST_IDLE;
                else if (axi.r_valid) state_d = ST_R_BURST;
                else                  to_set  = cmp_hit;
            end
            st_r_burst: begin
                if (r_done)     state_d = ST_IDLE;
                else if (!r_hs) to_set  = cmp_hit;
            end
            st_timeout: begin
                if (timeout_ack_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (to_set) state_d = ST_TIMEOUT;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            ph_q    <= PH_AR_READY;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            if (to_set) begin
                to_q <= 1'b1;
                ph_q <= cmp_phase;
            end else if (ack) begin
                to_q <= 1'b0;
                ph_q <= PH_AR_READY;
            end
        end
    end

    assign clr_all = rst_i | complete | ack;

    assign axi.ena_ar = ~rst_i & ((st_idle & axi.ar_valid) | st_ar_wait | st_r_wait);
    assign axi.ena_r  = ~rst_i & ((st_r_wait & axi.r_valid) | st_r_burst);

    assign axi.clear_arvld_arrdy = clr_all;
    assign axi.clear_arvld_rvld  = clr_all;
    assign axi.clear_rvld_rrdy   = clr_all | beat;
    assign axi.clear_rvld_rlast  = clr_all;

    assign busy_o          = busy_q;
    assign timeout_o       = to_q;
    assign timeout_phase_o = ph_q;

`ifdef READ_TRACKER_STATS_EN
    logic [31:0]             txn_q;
    logic [LatencyWidth-1:0] max_q;

    // Sampled on the cycle R_WAIT is left via r_valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            txn_q <= '0;
            max_q <= '0;
        end else begin
            if (complete && (txn_q != '1))
                txn_q <= txn_q + 32'd1;
            if (st_r_wait && axi.r_valid && (axi.latency_arvld_rvld > max_q))
                max_q <= axi.latency_arvld_rvld;
        end
    end

    assign txn_count_o      = txn_q;
    assign max_arvld_rvld_o = max_q;
`endif

endmodule

// File: tb/tb_read_txn_tracker.sv
// Scoreboard bench for read_txn_tracker with a simple latency counter model.
module tb_read_txn_tracker;

    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    read_txn_tracker_if #(.LatencyWidth(LW)) axi ();

    logic [LW-1:0] b_aa, b_ar, b_rr, b_rl;
    logic          ack;
    logic          busy;
    logic          tout;
    logic [1:0]    tph;
`ifdef READ_TRACKER_STATS_EN
    logic [31:0]   txn_count;
    logic [LW-1:0] max_ar;
`endif

    read_txn_tracker #(.LatencyWidth(LW)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .axi                  (axi),
        .budget_arvld_arrdy_i (b_aa),
        .budget_arvld_rvld_i  (b_ar),
        .budget_rvld_rrdy_i   (b_rr),
        .budget_rvld_rlast_i  (b_rl),
        .timeout_ack_i        (ack),
        .busy_o               (busy),
        .timeout_o            (tout),
`ifdef READ_TRACKER_STATS_EN
        .txn_count_o          (txn_count),
        .max_arvld_rvld_o     (max_ar),
`endif
        .timeout_phase_o      (tph)
    );

    // Counter unit model: registered count, clear has priority, enable adds one.
    logic [LW-1:0] c_aa, c_ar, c_rr, c_rl;
    always_ff @(posedge clk) begin
        c_aa <= axi.clear_arvld_arrdy ? '0 : c_aa + 32'(axi.ena_ar);
        c_ar <= axi.clear_arvld_rvld  ? '0 : c_ar + 32'(axi.ena_ar);
        c_rr <= axi.clear_rvld_rrdy   ? '0 : c_rr + 32'(axi.ena_r);
        c_rl <= axi.clear_rvld_rlast  ? '0 : c_rl + 32'(axi.ena_r);
    end
    assign axi.latency_arvld_arrdy = c_aa;
    assign axi.latency_arvld_rvld  = c_ar;
    assign axi.latency_rvld_rrdy   = c_rr;
    assign axi.latency_rvld_rlast  = c_rl;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [31:0] exp;
        logic [31:0] mask;
    } chk_t;

    chk_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic push(string nm, int sel, logic [31:0] e, logic [31:0] m);
        chk_t t;
        t.cyc  = cyc;
        t.nm   = nm;
        t.sel  = sel;
        t.exp  = e;
        t.mask = m;
        sb.push_back(t);
    endtask

    // Status vector: {busy, timeout, phase[1:0], ena_ar, ena_r, clears[3:0]}
    task automatic exp_clr(string nm, logic [3:0] v);
        push(nm, 0, {28'b0, v}, 32'h00F);
    endtask
    task automatic exp_ena(string nm, logic a, logic r);
        push(nm, 0, {26'b0, a, r, 4'b0}, 32'h030);
    endtask
    task automatic exp_busy(string nm, logic b);
        push(nm, 0, {22'b0, b, 9'b0}, 32'h200);
    endtask
    task automatic exp_to(string nm, logic t, logic [1:0] ph);
        push(nm, 0, {23'b0, t, ph, 6'b0}, t ? 32'h1C0 : 32'h100);
    endtask

    function automatic logic [31:0] actual(int sel);
        logic [31:0] a;
        a = {22'b0, busy, tout, tph, axi.ena_ar, axi.ena_r,
             axi.clear_arvld_arrdy, axi.clear_arvld_rvld,
             axi.clear_rvld_rrdy, axi.clear_rvld_rlast};
`ifdef READ_TRACKER_STATS_EN
        if (sel == 1) a = txn_count;
        if (sel == 2) a = max_ar;
`endif
        return a;
    endfunction

    // Monitor: pops every expectation due this cycle and compares mid-cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] a;
                a = actual(sb[i].sel) & sb[i].mask;
                n_chk++;
                if (sb[i].cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: stale check (due %0d, now %0d)",
                             sb[i].nm, sb[i].cyc, cyc);
                end else if (a !== (sb[i].exp & sb[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got %h want %h",
                             sb[i].nm, cyc, a, sb[i].exp & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic av, logic ar, logic rv, logic rr, logic rl, logic ak);
        axi.ar_valid = av;
        axi.ar_ready = ar;
        axi.r_valid  = rv;
        axi.r_ready  = rr;
        axi.r_last   = rl;
        ack          = ak;
    endtask

    task automatic budgets(int a, int b, int c, int d);
        b_aa = LW'(a);
        b_ar = LW'(b);
        b_rr = LW'(c);
        b_rl = LW'(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        budgets(0, 0, 0, 0);

        tick();
        exp_clr("rst_clr", 4'b1111);
        exp_ena("rst_ena", 1'b0, 1'b0);
        exp_busy("rst_busy", 1'b0);
        exp_to("rst_to", 1'b0, 2'd0);
        tick();
        rst = 1'b0;
        exp_clr("post_rst_clr", 4'b0000);
        tick();

        // Nominal transaction, ack outside TIMEOUT ignored
        budgets(8, 20, 6, 40);
        for (int k = 0; k <= 15; k++) begin
            tick();
            drive(k <= 3, k == 3, k >= 10 && k <= 13, k >= 10 && k <= 13,
                  k == 13, k == 5);
            if (k == 0) exp_ena("t1_ena_idle", 1'b1, 1'b0);
            if (k == 0) exp_busy("t1_busy_idle", 1'b0);
            if (k == 1) exp_busy("t1_busy", 1'b1);
            if (k == 5) exp_clr("t1_ack_ignored", 4'b0000);
            if (k == 5) exp_to("t1_to_rwait", 1'b0, 2'd0);
            if (k == 10) exp_ena("t1_ena_rwait", 1'b1, 1'b1);
            if (k == 11) exp_clr("t1_beat_clr", 4'b0010);
            if (k == 13) exp_clr("t1_done_clr", 4'b1111);
            if (k == 13) exp_ena("t1_ena_done", 1'b0, 1'b1);
            if (k == 14) exp_busy("t1_busy_low", 1'b0);
            if (k == 14) exp_to("t1_no_to", 1'b0, 2'd0);
        end

        // AR-ready timeout, phase 0, then acknowledge
        budgets(5, 0, 0, 0);
        for (int k = 0; k <= 11; k++) begin
            tick();
            drive(k <= 7, k == 7, 0, 0, 0, k == 9);
            if (k == 5) exp_to("t2_to_not_yet", 1'b0, 2'd0);
            if (k == 6) exp_to("t2_to_ph0", 1'b1, 2'd0);
            if (k == 7) exp_ena("t2_ena_off", 1'b0, 1'b0);
            if (k == 8) exp_to("t2_to_held", 1'b1, 2'd0);
            if (k == 8) exp_busy("t2_busy_to", 1'b1);
            if (k == 9) exp_clr("t2_ack_clr", 4'b1111);
            if (k == 10) exp_to("t2_to_cleared", 1'b0, 2'd0);
            if (k == 10) exp_busy("t2_busy_cleared", 1'b0);
        end

        // Phases 2 and 3 hit together: lowest code wins
        budgets(0, 0, 3, 3);
        for (int k = 0; k <= 8; k++) begin
            tick();
            drive(k == 0, k == 0, k >= 1 && k <= 4, 0, 0, k == 6);
            if (k == 4) exp_to("t3_to_not_yet", 1'b0, 2'd0);
            if (k == 5) exp_to("t3_ph2", 1'b1, 2'd2);
            if (k == 6) exp_clr("t3_ack_clr", 4'b1111);
            if (k == 7) exp_to("t3_to_cleared", 1'b0, 2'd0);
        end

        // Handshake on the budget cycle wins; then reset from R_BURST
        budgets(5, 0, 0, 0);
        for (int k = 0; k <= 11; k++) begin
            tick();
            rst = (k == 9 || k == 10);
            drive(k <= 5, k == 5, k >= 7 && k <= 10, 0, 0, 0);
            if (k == 6) exp_to("t4_hs_wins", 1'b0, 2'd0);
            if (k == 6) exp_ena("t4_rwait_ena", 1'b1, 1'b0);
            if (k == 8) exp_busy("t4_busy_burst", 1'b1);
            if (k == 9) exp_clr("t4_rst_clr", 4'b1111);
            if (k == 9) exp_ena("t4_rst_ena", 1'b0, 1'b0);
            if (k == 10) exp_busy("t4_rst_busy", 1'b0);
            if (k == 10) exp_clr("t4_rst_clr2", 4'b1111);
            if (k == 11) exp_clr("t4_post_clr", 4'b0000);
`ifdef READ_TRACKER_STATS_EN
            if (k == 11) push("t4_stats_rst", 1, 32'd0, 32'hFFFF_FFFF);
`endif
        end

        // Three transactions with AR-to-R latencies 7, 12, 9
        budgets(0, 0, 0, 0);
        for (int t = 0; t < 3; t++) begin
            int lat;
            lat = (t == 0) ? 7 : (t == 1) ? 12 : 9;
            for (int k = 0; k <= lat + 1; k++) begin
                tick();
                drive(k == 0, k == 0, k == lat, k == lat, k == lat, 0);
                if (k == lat) exp_clr("s_done_clr", 4'b1111);
                if (k == lat + 1) exp_busy("s_busy_low", 1'b0);
`ifdef READ_TRACKER_STATS_EN
                if (t == 0 && k == lat + 1)
                    push("s_max_first", 2, 32'd7, 32'hFFFF_FFFF);
`endif
            end
        end
`ifdef READ_TRACKER_STATS_EN
        push("s_txn_count", 1, 32'd3, 32'hFFFF_FFFF);
        push("s_max", 2, 32'd12, 32'hFFFF_FFFF);
`endif

        // Zero budget, 1000-cycle AR stall, completion straight from R_WAIT
        for (int k = 0; k <= 1003; k++) begin
            tick();
            drive(k <= 1000, k == 1000, k == 1001, k == 1001, k == 1001, 0);
            if (k == 500) exp_to("stall_to_mid", 1'b0, 2'd0);
            if (k == 500) exp_busy("stall_busy", 1'b1);
            if (k == 999) exp_to("stall_to_end", 1'b0, 2'd0);
            if (k == 1001) exp_clr("stall_done_clr", 4'b1111);
            if (k == 1002) exp_busy("stall_busy_low", 1'b0);
            if (k == 1002) exp_to("stall_no_to", 1'b0, 2'd0);
`ifdef READ_TRACKER_STATS_EN
            if (k == 1002) push("stall_txn", 1, 32'd4, 32'hFFFF_FFFF);
            if (k == 1002) push("stall_max", 2, 32'd1001, 32'hFFFF_FFFF);
`endif
        end

        tick();
        tick();
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
